// File: rtl/pairing_host_ctrl.sv
// rtl/pairing_host_ctrl.sv - host job controller for the BN254 pairing engine load/run/readout port
// Optional feature macro: PAIRING_HOST_TIMEOUT_EN (completion timeout with engine soft reset and err flag)

module pairing_host_ctrl #(
    parameter int          DW             = 304,
    parameter int          AW             = 9,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd16777215
) (
    input  logic          clk,
    input  logic          swrst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_func,
    input  logic [AW-1:0] cmd_ld_base,
    input  logic [AW:0]   cmd_ld_len,
    input  logic [AW-1:0] cmd_rd_base,
    input  logic [AW:0]   cmd_rd_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          done,
    output logic          err,
    output logic          pa_run,
    output logic          pa_swrst,
    output logic          pa_extin_en,
    output logic [3:0]    pa_n_func,
    output logic [AW-1:0] pa_extin_addr,
    output logic [AW-1:0] pa_extout_addr,
    output logic [DW-1:0] pa_extin_data,
    input  logic          pa_busy,
    input  logic          pa_endflag,
    input  logic [DW-1:0] pa_extout_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_BUSY, S_WAIT_END, S_UNLOAD, S_DONE
    } state_t;

    localparam logic [AW:0] ONE = (AW+1)'(1);

    state_t        state_q, state_d;
    logic [3:0]    func_q, func_d;
    logic [AW-1:0] ld_ptr_q, ld_ptr_d;
    logic [AW:0]   ld_cnt_q, ld_cnt_d, ld_len_q, ld_len_d;
    logic [AW-1:0] rd_base_q, rd_base_d;
    logic [AW:0]   rd_len_q, rd_len_d, issued_q, issued_d, popped_q, popped_d;

    // Read pipeline tracker and 4-entry output FIFO
    logic [1:0]    infl_q;
    logic [DW-1:0] fifo_q [4];
    logic [1:0]    wr_q, rd_q;
    logic [2:0]    fcnt_q;
    logic          issue, push, pop, tmo_fire;

    logic          cmd_ready_c, in_ready_c, extin_en_c, run_c, done_c;
    logic          out_valid_c, out_last_c;
    logic [AW-1:0] extin_addr_c, extout_addr_c;
    logic [DW-1:0] extin_data_c;

`ifdef PAIRING_HOST_TIMEOUT_EN
    logic          err_q, err_d;
    logic [23:0]   tmo_q, tmo_d;
`else
    logic          unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    assign push        = infl_q[1];
    assign out_valid_c = (fcnt_q != 3'd0);
    assign pop         = out_valid_c & out_ready;
    assign out_last_c  = out_valid_c && (popped_q == rd_len_q - ONE);

    // Next-state and output decode for the job sequence
    always_comb begin
        state_d   = state_q;
        func_d    = func_q;
        ld_ptr_d  = ld_ptr_q;
        ld_cnt_d  = ld_cnt_q;
        ld_len_d  = ld_len_q;
        rd_base_d = rd_base_q;
        rd_len_d  = rd_len_q;
        issued_d  = issued_q;
        popped_d  = pop ? popped_q + ONE : popped_q;
        cmd_ready_c   = 1'b0;
        in_ready_c    = 1'b0;
        extin_en_c    = 1'b0;
        extin_addr_c  = '0;
        extin_data_c  = '0;
        extout_addr_c = '0;
        run_c         = 1'b0;
        done_c        = 1'b0;
        issue         = 1'b0;
        tmo_fire      = 1'b0;
`ifdef PAIRING_HOST_TIMEOUT_EN
        err_d = err_q;
        tmo_d = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                cmd_ready_c = 1'b1;
                if (cmd_valid) begin
                    func_d    = cmd_func;
                    ld_ptr_d  = cmd_ld_base;
                    ld_len_d  = cmd_ld_len;
                    ld_cnt_d  = '0;
                    rd_base_d = cmd_rd_base;
                    rd_len_d  = cmd_rd_len;
                    issued_d  = '0;
                    popped_d  = '0;
`ifdef PAIRING_HOST_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    state_d = (cmd_ld_len != '0) ? S_LOAD : S_START;
                end
            end
            S_LOAD: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    extin_en_c   = 1'b1;
                    extin_addr_c = ld_ptr_q;
                    extin_data_c = in_data;
                    ld_ptr_d     = ld_ptr_q + AW'(1);
                    ld_cnt_d     = ld_cnt_q + ONE;
                    if (ld_cnt_q + ONE == ld_len_q) state_d = S_START;
                end
            end
            S_START: begin
                run_c   = 1'b1;
                state_d = S_WAIT_BUSY;
`ifdef PAIRING_HOST_TIMEOUT_EN
                tmo_d = '0;
`endif
            end
            // Waiting for busy first keeps a stale endflag from ending the job early
            S_WAIT_BUSY: if (pa_busy) state_d = S_WAIT_END;
            S_WAIT_END: begin
                if (pa_endflag && !pa_busy) state_d = (rd_len_q != '0) ? S_UNLOAD : S_DONE;
            end
            S_UNLOAD: begin
                extout_addr_c = rd_base_q + issued_q[AW-1:0];
                // Reserve a FIFO slot for every read in flight so backpressure never overflows it
                issue = (issued_q < rd_len_q) &&
                        (({1'b0, fcnt_q} + {3'b0, infl_q[0]} + {3'b0, infl_q[1]}) < 4'd4);
                if (issue) issued_d = issued_q + ONE;
                if (pop && out_last_c) state_d = S_DONE;
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef PAIRING_HOST_TIMEOUT_EN
        if (state_q == S_WAIT_BUSY || state_q == S_WAIT_END) begin
            if (tmo_q + 24'd1 == TIMEOUT_CYCLES) begin
                tmo_fire = 1'b1;
                err_d    = 1'b1;
                state_d  = S_DONE;
            end else begin
                tmo_d = tmo_q + 24'd1;
            end
        end
`endif
    end

    // State, job fields and read/FIFO bookkeeping registers
    always_ff @(posedge clk) begin
        if (swrst) begin
            state_q   <= S_IDLE;
            func_q    <= '0;
            ld_ptr_q  <= '0;
            ld_cnt_q  <= '0;
            ld_len_q  <= '0;
            rd_base_q <= '0;
            rd_len_q  <= '0;
            issued_q  <= '0;
            popped_q  <= '0;
            infl_q    <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            fcnt_q    <= '0;
`ifdef PAIRING_HOST_TIMEOUT_EN
            err_q <= 1'b0;
            tmo_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            func_q    <= func_d;
            ld_ptr_q  <= ld_ptr_d;
            ld_cnt_q  <= ld_cnt_d;
            ld_len_q  <= ld_len_d;
            rd_base_q <= rd_base_d;
            rd_len_q  <= rd_len_d;
            issued_q  <= issued_d;
            popped_q  <= popped_d;
            infl_q    <= {infl_q[0], issue};
            if (push) wr_q <= wr_q + 2'd1;
            if (pop)  rd_q <= rd_q + 2'd1;
            fcnt_q    <= fcnt_q + {2'b0, push} - {2'b0, pop};
`ifdef PAIRING_HOST_TIMEOUT_EN
            err_q <= err_d;
            tmo_q <= tmo_d;
`endif
        end
    end

    // FIFO storage captures engine read data two cycles after each issued address
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q] <= pa_extout_data;
    end

    assign cmd_ready      = cmd_ready_c & ~swrst;
    assign in_ready       = in_ready_c & ~swrst;
    assign out_valid      = out_valid_c & ~swrst;
    assign out_last       = out_last_c & ~swrst;
    assign out_data       = swrst ? '0 : fifo_q[rd_q];
    assign done           = done_c & ~swrst;
    assign pa_run         = run_c & ~swrst;
    assign pa_swrst       = swrst | tmo_fire;
    assign pa_extin_en    = extin_en_c & ~swrst;
    assign pa_n_func      = swrst ? 4'd0 : func_q;
    assign pa_extin_addr  = swrst ? '0 : extin_addr_c;
    assign pa_extin_data  = swrst ? '0 : extin_data_c;
    assign pa_extout_addr = swrst ? '0 : extout_addr_c;
`ifdef PAIRING_HOST_TIMEOUT_EN
    assign err = err_q & ~swrst;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pairing_host_ctrl.sv
// tb/tb_pairing_host_ctrl.sv - randomized self-checking bench for pairing_host_ctrl with an engine model

module tb_pairing_host_ctrl;

    localparam int DW = 304;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          swrst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_func = '0;
    logic [AW-1:0] cmd_ld_base = '0, cmd_rd_base = '0;
    logic [AW:0]   cmd_ld_len = '0, cmd_rd_len = '0;
    logic          in_valid = 1'b0, in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid, out_ready = 1'b0, out_last;
    logic [DW-1:0] out_data;
    logic          done, err, pa_run, pa_swrst, pa_extin_en;
    logic [3:0]    pa_n_func;
    logic [AW-1:0] pa_extin_addr, pa_extout_addr;
    logic [DW-1:0] pa_extin_data, pa_extout_data;
    logic          pa_busy, pa_endflag;

    pairing_host_ctrl #(.DW(DW), .AW(AW), .TIMEOUT_CYCLES(24'd50)) dut (
        .clk(clk), .swrst(swrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
        .cmd_ld_base(cmd_ld_base), .cmd_rd_base(cmd_rd_base),
        .cmd_ld_len(cmd_ld_len), .cmd_rd_len(cmd_rd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .done(done), .err(err),
        .pa_run(pa_run), .pa_swrst(pa_swrst), .pa_extin_en(pa_extin_en), .pa_n_func(pa_n_func),
        .pa_extin_addr(pa_extin_addr), .pa_extout_addr(pa_extout_addr),
        .pa_extin_data(pa_extin_data),
        .pa_busy(pa_busy), .pa_endflag(pa_endflag), .pa_extout_data(pa_extout_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: busy 2 cycles after run for 100 cycles, then endflag held until next busy
    logic [DW-1:0] ram [512];
    logic [AW-1:0] a1, a2;
    bit eng_on = 0, stale = 0, never_busy = 0;
    int et = 0;
    wire eng_busy = eng_on && !never_busy && et >= 2 && et < 102;
    wire eng_end  = eng_on && !never_busy && et >= 102;
    assign pa_busy        = eng_busy;
    assign pa_endflag     = eng_end | stale;
    assign pa_extout_data = ram[a2];

    always @(posedge clk) begin
        if (pa_swrst) begin
            eng_on <= 0;
            stale  <= 0;
        end else begin
            if (pa_run) begin
                eng_on <= 1;
                et     <= 1;
                if (pa_endflag) stale <= 1;
            end else if (eng_on) et <= et + 1;
            if (eng_busy) stale <= 0;
            if (pa_extin_en && !pa_busy) ram[pa_extin_addr] <= pa_extin_data;
        end
        a1 <= pa_extout_addr;
        a2 <= a1;
    end

    // Observation log, sampled on the falling edge
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$], od_q[$];
    bit            ol_q[$];
    int wc_q[$], oc_q[$], run_q[$], done_q[$], acc_q[$], endr_q[$], orise_q[$], swp_q[$];
    int busy_viol = 0;
    bit ov_prev = 0, end_prev = 0;

    always @(negedge clk) begin
        if (!swrst) begin
            if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
            if (pa_extin_en) begin
                wa_q.push_back(pa_extin_addr); wd_q.push_back(pa_extin_data); wc_q.push_back(cyc);
            end
            if (pa_run) run_q.push_back(cyc);
            if (out_valid && out_ready) begin
                od_q.push_back(out_data); ol_q.push_back(out_last); oc_q.push_back(cyc);
            end
            if (out_valid && !ov_prev) orise_q.push_back(cyc);
            if (done) done_q.push_back(cyc);
            if (pa_endflag && !pa_busy && !end_prev) endr_q.push_back(cyc);
            if (pa_swrst) swp_q.push_back(cyc);
            if (pa_busy && (pa_extin_en || pa_extout_addr != '0)) busy_viol++;
        end
        ov_prev  = out_valid;
        end_prev = pa_endflag && !pa_busy;
    end

    int vectors = 0, miscompares = 0;
    logic [DW-1:0] ref_ram [512];
    logic [DW-1:0] exp_q[$];
    int b_wr, b_out, b_run, b_done, b_acc, b_end, b_orise, b_swp, nerr;

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w = '0;
        for (int k = 0; k < DW; k += 32) w = {w[DW-33:0], $urandom()};
        return w;
    endfunction

    // Runs one job: reference RAM updated from the plain rules, then stimulus until done
    task automatic run_job(input logic [3:0] f, input int ldb, input int ldl, input int rdb,
                           input int rdl, input bit gaps, input bit seq, input int rdy_mode);
        logic [DW-1:0] words[$];
        int idx = 0, n;
        bit got_done = 0;
        for (int i = 0; i < ldl; i++) words.push_back(seq ? DW'(i + 1) : rand_word());
        for (int i = 0; i < ldl; i++) ref_ram[(ldb + i) % 512] = words[i];
        exp_q.delete();
        for (int i = 0; i < rdl; i++) exp_q.push_back(ref_ram[(rdb + i) % 512]);
        b_wr = wa_q.size(); b_out = od_q.size(); b_run = run_q.size(); b_done = done_q.size();
        b_acc = acc_q.size(); b_end = endr_q.size(); b_orise = orise_q.size(); b_swp = swp_q.size();
        @(posedge clk); #1;
        cmd_valid = 1; cmd_func = f;
        cmd_ld_base = AW'(ldb); cmd_ld_len = (AW+1)'(ldl);
        cmd_rd_base = AW'(rdb); cmd_rd_len = (AW+1)'(rdl);
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 100);
        for (n = 0; n < 6000; n++) begin
            @(posedge clk); #1;
            cmd_valid = 0;
            in_valid  = (idx < ldl) && (!gaps || $urandom_range(3) != 0);
            in_data   = (idx < ldl) ? words[idx] : '0;
            out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(1));
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (done) begin got_done = 1; break; end
        end
        @(posedge clk); #1;
        in_valid = 0; out_ready = 0;
        vectors++;
        if (!got_done) begin
            miscompares++;
            $display("FAIL job_done_timeout: got no done within bound, required done pulse");
        end
    endtask

    task automatic test_reset;
        int d0;
        for (int p = 0; p < 2; p++) begin
            if (p == 1) begin
                @(posedge clk); #1;
                cmd_valid = 1; cmd_func = 4'h5; cmd_ld_base = 9'd100; cmd_ld_len = 10'd8;
                @(posedge clk); #1;
                cmd_valid = 0; in_valid = 1; in_data = rand_word();
                @(posedge clk); #1;
                in_data = rand_word();
            end
            d0 = done_q.size();
            @(posedge clk); #1;
            swrst = 1; cmd_valid = 1; in_valid = 1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                vectors += 4;
                if ({cmd_ready, in_ready, out_valid, out_last, done, err, pa_run, pa_extin_en} !== 8'b0) begin
                    miscompares++;
                    $display("FAIL rst_ctrl: got %b required 00000000",
                             {cmd_ready, in_ready, out_valid, out_last, done, err, pa_run, pa_extin_en});
                end
                if ({pa_n_func, pa_extin_addr, pa_extout_addr} !== 22'd0) begin
                    miscompares++;
                    $display("FAIL rst_addr: got %h required 0", {pa_n_func, pa_extin_addr, pa_extout_addr});
                end
                if (pa_extin_data !== '0 || out_data !== '0) begin
                    miscompares++;
                    $display("FAIL rst_data: got extin %h out %h required 0", pa_extin_data, out_data);
                end
                if (pa_swrst !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rst_pa_swrst: got %b required 1", pa_swrst);
                end
                if (k < 2) begin @(posedge clk); #1; end
            end
            @(posedge clk); #1;
            swrst = 0; cmd_valid = 0; in_valid = 0;
            @(negedge clk);
            vectors++;
            if (cmd_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL rst_cmd_ready_after: got %b required 1", cmd_ready);
            end
            repeat (10) @(negedge clk);
            vectors++;
            if (done_q.size() != d0) begin
                miscompares++;
                $display("FAIL rst_no_done: got %0d done pulses required 0", done_q.size() - d0);
            end
        end
    endtask

    task automatic test_full_load;
        int ldb = $urandom_range(511), rdb = $urandom_range(511);
        run_job(4'h3, ldb, 512, rdb, 512, 1, 0, 2);
        vectors++;
        if (wa_q.size() - b_wr != 512) begin
            miscompares++;
            $display("FAIL full_load_count: got %0d writes required 512", wa_q.size() - b_wr);
        end
        nerr = 0;
        for (int i = 0; i < 512 && b_wr + i < wa_q.size(); i++)
            if (int'(wa_q[b_wr + i]) != (ldb + i) % 512) nerr++;
        vectors++;
        if (nerr != 0) begin
            miscompares++;
            $display("FAIL full_load_addr: got %0d wrong addresses required 0", nerr);
        end
        nerr = 0;
        for (int i = 0; i < 512 && b_out + i < od_q.size(); i++)
            if (od_q[b_out + i] !== exp_q[i] || ol_q[b_out + i] != (i == 511)) nerr++;
        vectors += 2;
        if (od_q.size() - b_out != 512) begin
            miscompares++;
            $display("FAIL full_read_count: got %0d words required 512", od_q.size() - b_out);
        end
        if (nerr != 0) begin
            miscompares++;
            $display("FAIL full_read_data: got %0d bad words required 0", nerr);
        end
    endtask

    task automatic test_load_wrap;
        int acc;
        run_job(4'h1, 510, 4, 0, 0, 0, 1, 0);
        acc = acc_q[b_acc];
        vectors++;
        if (wa_q.size() - b_wr != 4) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d writes required 4", wa_q.size() - b_wr);
        end
        for (int i = 0; i < 4 && b_wr + i < wa_q.size(); i++) begin
            vectors++;
            if (int'(wa_q[b_wr + i]) != (510 + i) % 512 || wd_q[b_wr + i] !== DW'(i + 1) ||
                wc_q[b_wr + i] != acc + 1 + i) begin
                miscompares++;
                $display("FAIL wrap_write%0d: got addr %0d data %0h cyc %0d required addr %0d data %0d cyc %0d",
                         i, wa_q[b_wr + i], wd_q[b_wr + i], wc_q[b_wr + i], (510 + i) % 512, i + 1, acc + 1 + i);
            end
        end
        vectors++;
        if (run_q.size() - b_run != 1 || run_q[b_run] != acc + 5) begin
            miscompares++;
            $display("FAIL wrap_run: got %0d pulses first at %0d required 1 at %0d",
                     run_q.size() - b_run, run_q[b_run], acc + 5);
        end
    endtask

    task automatic test_full_job;
        run_job(4'hA, 8, 3, 8, 3, 0, 0, 0);
        vectors++;
        if (od_q.size() - b_out != 3) begin
            miscompares++;
            $display("FAIL job_count: got %0d words required 3", od_q.size() - b_out);
        end
        for (int i = 0; i < 3 && b_out + i < od_q.size(); i++) begin
            vectors++;
            if (od_q[b_out + i] !== exp_q[i] || ol_q[b_out + i] != (i == 2)) begin
                miscompares++;
                $display("FAIL job_word%0d: got %h last %0d required %h last %0d",
                         i, od_q[b_out + i], ol_q[b_out + i], exp_q[i], i == 2);
            end
        end
        vectors += 4;
        if (done_q[b_done] != oc_q[oc_q.size() - 1] + 1) begin
            miscompares++;
            $display("FAIL job_done_cycle: got %0d required %0d", done_q[b_done], oc_q[oc_q.size() - 1] + 1);
        end
        if (orise_q[b_orise] != endr_q[b_end] + 4) begin
            miscompares++;
            $display("FAIL job_read_latency: got %0d required %0d", orise_q[b_orise], endr_q[b_end] + 4);
        end
        if (run_q[b_run] != wc_q[wc_q.size() - 1] + 1) begin
            miscompares++;
            $display("FAIL job_run_cycle: got %0d required %0d", run_q[b_run], wc_q[wc_q.size() - 1] + 1);
        end
        if (pa_n_func !== 4'hA) begin
            miscompares++;
            $display("FAIL job_func_hold: got %h required a", pa_n_func);
        end
    endtask

    task automatic test_backpressure;
        run_job(4'h2, 0, 0, $urandom_range(511), 16, 0, 0, 1);
        vectors += 2;
        if (od_q.size() - b_out != 16) begin
            miscompares++;
            $display("FAIL bp_count: got %0d words required 16", od_q.size() - b_out);
        end
        nerr = 0;
        for (int i = 0; i < 16 && b_out + i < od_q.size(); i++)
            if (od_q[b_out + i] !== exp_q[i] || ol_q[b_out + i] != (i == 15)) nerr++;
        if (nerr != 0) begin
            miscompares++;
            $display("FAIL bp_data: got %0d bad words required 0", nerr);
        end
    endtask

    task automatic test_zero_lengths;
        run_job(4'h7, 0, 0, 0, 0, 0, 0, 0);
        vectors += 3;
        if (run_q[b_run] != acc_q[b_acc] + 1) begin
            miscompares++;
            $display("FAIL zero_run: got %0d required %0d", run_q[b_run], acc_q[b_acc] + 1);
        end
        if (done_q[b_done] != endr_q[b_end] + 1) begin
            miscompares++;
            $display("FAIL zero_done: got %0d required %0d", done_q[b_done], endr_q[b_end] + 1);
        end
        if (orise_q.size() != b_orise || wa_q.size() != b_wr) begin
            miscompares++;
            $display("FAIL zero_no_traffic: got %0d out_valid rises %0d writes required 0 0",
                     orise_q.size() - b_orise, wa_q.size() - b_wr);
        end
    endtask

    task automatic test_random_jobs;
        for (int j = 0; j < 6; j++) begin
            int ldl = $urandom_range(40), rdl = $urandom_range(40);
            run_job(4'($urandom_range(15)), $urandom_range(511), ldl, $urandom_range(511), rdl, 1, 0, 2);
            nerr = 0;
            for (int i = 0; i < rdl && b_out + i < od_q.size(); i++)
                if (od_q[b_out + i] !== exp_q[i]) nerr++;
            vectors++;
            if (od_q.size() - b_out != rdl || wa_q.size() - b_wr != ldl || nerr != 0) begin
                miscompares++;
                $display("FAIL rand_job%0d: got %0d words %0d writes %0d bad required %0d %0d 0",
                         j, od_q.size() - b_out, wa_q.size() - b_wr, nerr, rdl, ldl);
            end
        end
    endtask

`ifdef PAIRING_HOST_TIMEOUT_EN
    task automatic test_timeout;
        never_busy = 1;
        run_job(4'h6, 0, 0, 0, 5, 0, 0, 0);
        vectors += 4;
        if (swp_q.size() - b_swp != 1 || swp_q[b_swp] != run_q[b_run] + 50) begin
            miscompares++;
            $display("FAIL tmo_swrst: got %0d pulses first at %0d required 1 at %0d",
                     swp_q.size() - b_swp, swp_q[b_swp], run_q[b_run] + 50);
        end
        if (done_q[b_done] != run_q[b_run] + 51) begin
            miscompares++;
            $display("FAIL tmo_done: got %0d required %0d", done_q[b_done], run_q[b_run] + 51);
        end
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_err_set: got %b required 1", err);
        end
        if (od_q.size() != b_out) begin
            miscompares++;
            $display("FAIL tmo_no_words: got %0d required 0", od_q.size() - b_out);
        end
        never_busy = 0;
        run_job(4'h0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_err_clear: got %b required 0", err);
        end
    endtask
`else
    task automatic test_err_tied;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_tied: got %b required 0", err);
        end
    endtask
`endif

    task automatic test_busy_guard;
        vectors++;
        if (busy_viol != 0) begin
            miscompares++;
            $display("FAIL busy_guard: got %0d extin/extout cycles while busy required 0", busy_viol);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_load_wrap();
        test_full_job();
        test_backpressure();
        test_zero_lengths();
        test_random_jobs();
`ifdef PAIRING_HOST_TIMEOUT_EN
        test_timeout();
`else
        test_err_tied();
`endif
        test_busy_guard();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pairing_host_ctrl.md
# pairing_host_ctrl

Host-side job controller that drives the external load/readout port of the BN254 pairing engine. It accepts one job command, then:
- streams operand words from a valid/ready input into engine RAM;
- issues the run pulse and waits for completion;
- reads a result window back through the engine's 2-cycle readout path and presents it on a valid/ready output stream.

It is the initiator for the engine's `extin_*` / `extout_*` / `run` / `endflag` interface.

## Interface
- `DW`, 304, bits per redundant L3 polynomial word (engine RAM word).
- `AW`, 9, engine RAM address width (512 words).
- `TIMEOUT_CYCLES`, 24'd16777215, completion timeout. Used only with `PAIRING_HOST_TIMEOUT_EN`.

- `clk`  in  1  single clock, shared with the engine.
- `swrst`  in  1  reset, synchronous, active-high.
- `cmd_valid` / `cmd_ready`  in / out  1 / 1  job command handshake.
- `cmd_func`  in  4  value driven on `pa_n_func`.
- `cmd_ld_base`, `cmd_rd_base`  in  AW  load / readout start address.
- `cmd_ld_len`, `cmd_rd_len`  in  AW+1  word counts, 0..512.
- `in_valid` / `in_ready` / `in_data`  in / out / in  1 / 1 / DW  operand stream.
- `out_valid` / `out_ready` / `out_data` / `out_last`  out / in / out / out  1 / 1 / DW / 1  result stream.
- `done`  out  1  one-cycle pulse at job end.
- `err`  out  1  sticky timeout flag. Cleared by accepting a new command.
- `pa_run`, `pa_swrst`, `pa_extin_en`  out  1  engine controls.
- `pa_n_func`  out  4  engine function select.
- `pa_extin_addr`, `pa_extout_addr`  out  AW  engine addresses.
- `pa_extin_data`  out  DW  engine write data.
- `pa_busy`, `pa_endflag`  in  1  engine status.
- `pa_extout_data`  in  DW  engine read data.

## Operation
States: IDLE, LOAD, START, WAIT_BUSY, WAIT_END, UNLOAD, DONE.

- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch all fields and clear `err`.
  - Next state: LOAD if `ld_len`≠0, else START.
- **LOAD**
  - `in_ready`=1.
  - Each `in_valid&in_ready` transfer drives, in the same cycle: `pa_extin_en`=1, `pa_extin_addr`=ptr, `pa_extin_data`=`in_data`.
  - After each transfer: ptr++ (wraps mod 2^AW), count++.
  - After the `ld_len`-th word: go to START.
- **START**
  - Drive `pa_run`=1 for exactly one cycle with `pa_n_func`=`cmd_func`.
  - Next state: WAIT_BUSY.
- **WAIT_BUSY**
  - Stay until `pa_busy`=1.
  - This guards against a stale `pa_endflag` from the previous job.
- **WAIT_END**
  - Stay until `pa_endflag`=1 and `pa_busy`=0.
  - Next state: UNLOAD if `rd_len`≠0, else DONE.
- **UNLOAD**
  - Drive `pa_extout_addr`=`rd_base`+issued (wraps mod 2^AW).
  - Read data returns exactly 2 cycles after the address is presented. A 2-deep valid shift register tracks reads in flight.
  - Returned words enter a 4-entry output FIFO.
  - Issue a new read only when issued<`rd_len` and fifo_count + inflight < 4. The FIFO therefore never overflows, even if `out_ready` is held low indefinitely.
  - `out_last`=1 on the `rd_len`-th word.
  - Go to DONE when that word is accepted.
- **DONE**
  - `done`=1 for one cycle, then IDLE.
- **Global rules**
  - `pa_n_func` holds the latched `cmd_func` in every state.
  - The LOAD and UNLOAD address/enable outputs are 0 in all other states.
  - The engine ignores `extin` and `extout_addr` while busy. The state sequence guarantees the controller never drives them while `pa_busy`=1.
  - Output FIFO: flushed on `swrst`. Ordering strictly matches address order.

## Timing
- **Reset:** `swrst`=1 forces IDLE, flushes the FIFO and clears the in-flight tracker.
  - Values held during reset: `cmd_ready`=0, all other outputs 0, `pa_swrst`=1.
  - First cycle after reset: `cmd_ready`=1.
  - Reset mid-job abandons the job; no `done` pulse is produced.
- **Load:** zero-bubble, one word per cycle while `in_valid`=1.
- **Start:** `pa_run` is asserted in the cycle after the last load write, or the cycle after command accept when `ld_len`=0.
- **Readout latency:** first `out_valid` appears 3 cycles after entering UNLOAD (2 RAM cycles + 1 FIFO register).
  - Sustained rate is 1 word/cycle with `out_ready`=1.
- **Simultaneous events:**
  - `cmd_valid` in DONE is not accepted until IDLE.
  - A FIFO push and pop in the same cycle leaves the count unchanged.

## Configuration
- `PAIRING_HOST_TIMEOUT_EN` defined:
  - A 24-bit counter runs during WAIT_BUSY and WAIT_END, cleared on entering WAIT_BUSY.
  - When it reaches `TIMEOUT_CYCLES`: pulse `pa_swrst` for 1 cycle, set `err`, skip UNLOAD, go to DONE.
- `PAIRING_HOST_TIMEOUT_EN` undefined:
  - No counter; the controller waits indefinitely.
  - `err` is tied to 0.
  - `pa_swrst` follows `swrst` only.

## Test plan
- **Reset:** `swrst` held 3 cycles mid-LOAD -> all outputs 0 and `pa_swrst`=1 during reset; `cmd_ready`=1 the cycle after; no `done`.
- **Load wrap:** `ld_base`=510, `ld_len`=4, data 1..4 -> writes to addr 510, 511, 0, 1 in consecutive cycles; `pa_run` pulses once the following cycle.
- **Full job:** engine model asserts busy 2 cycles after run and endflag 100 cycles later; `rd_base`=8, `rd_len`=3 -> out words equal RAM[8..10]; `out_last` on the third word; `done` one cycle after its acceptance.
- **Backpressure:** `rd_len`=16, `out_ready` toggling 1-of-3 cycles -> no word lost or duplicated; reads in flight plus FIFO count never exceed 4.
- **Zero lengths:** `ld_len`=0, `rd_len`=0 -> `pa_run` the cycle after accept; `done` after endflag; `out_valid` never asserted.
- **Timeout** (macro defined, `TIMEOUT_CYCLES`=50): engine never asserts busy -> `pa_swrst` pulse at cycle 50 of WAIT_BUSY, `err`=1, `done` pulse, no output words.
